onewire_slave_phy: RTL and testbench
====================================

ONEWIRE_SLAVE_PHY -- requirements
Module: onewire_slave_phy

Interface
REQ-001 Parameter: CLK_MHZ, default 50, clock frequency in MHz; all timing thresholds SHALL be us * CLK_MHZ cycles; legal range 10..100.
REQ-002 clk  input  1  system clock, single clock domain.
REQ-003 nRst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 IO_i  input  1  1-Wire bus level, asynchronous.
REQ-005 IO_o  output  1  open-drain drive; 0 = pull bus low, 1 = release.
REQ-006 od_set  input  1  one-cycle pulse from the command layer; enters overdrive.
REQ-007 tx_en  input  1  next slot is a read slot; the PHY answers with tx_bit.
REQ-008 tx_bit  input  1  bit to return in a read slot; latched at the slot's falling edge.
REQ-009 reset_det  output  1  one-cycle pulse: a valid reset was detected.
REQ-010 bit_valid  output  1  one-cycle pulse: a slot bit is available.
REQ-011 bit_data  output  1  slot bit; valid only while bit_valid=1.
REQ-012 od_mode  output  1  1 = overdrive timing active.

Function
REQ-013 IO_i SHALL pass through a 2-FF synchronizer (reset value 1); a falling edge is sync==0 with the previous sync==1.
REQ-014 The 16-bit low-time counter SHALL clear on a falling edge, increment each cycle while the synchronized bus is 0, and saturate at 0xFFFF.
REQ-015 The FSM states are IDLE, LOW, PRES_WAIT and PRES_DRIVE.
REQ-016 IDLE -> LOW on a falling edge: latch tx_en/tx_bit and od_mode timing.
REQ-017 In LOW with a read slot and latched tx_bit=0: IO_o=0 from the falling-edge cycle until count == tRDV (std 30us, OD 3us), then 1; latched tx_bit=1 keeps IO_o=1.
REQ-018 In LOW, when count == tSAMP (std 30us, OD 3us): emit bit_valid for one cycle.
REQ-019 bit_data = latched tx_bit for a read slot, otherwise the synchronized bus value.
REQ-020 Bus low shorter than tSAMP: emit no bit; return to IDLE on the rising edge.
REQ-021 LOW on rising edge, count >= 480us*CLK_MHZ: standard reset; reset_det=1, od_mode<=0, -> PRES_WAIT.
REQ-022 LOW on rising edge, else if od_mode=1 and count >= 48us*CLK_MHZ: overdrive reset; reset_det=1, od_mode unchanged, -> PRES_WAIT.
REQ-023 LOW on rising edge, otherwise: -> IDLE.
REQ-024 In standard mode, a low of 48..479us is an ordinary slot; it SHALL NOT produce reset_det.
REQ-025 PRES_WAIT: wait tPDH (std 30us, OD 3us) from entry -> PRES_DRIVE.
REQ-026 PRES_DRIVE: IO_o=0 for tPDL (std 120us, OD 12us), then IO_o=1 -> IDLE.
REQ-027 Presence timing SHALL use the od_mode value after the reset decision.
REQ-028 Falling edge in PRES_WAIT: abandon presence -> LOW with bit output suppressed until the next rising edge; reset evaluation still applies.
REQ-029 Bus activity during PRES_DRIVE SHALL be ignored.
REQ-030 od_set SHALL set od_mode in any state; the new timing takes effect at the next falling edge.
REQ-031 od_set in the same cycle as a standard-reset decision: the reset wins and od_mode=0.
REQ-032 bit_valid and reset_det SHALL never assert in the same cycle.
REQ-033 Latency from the bus falling edge to IO_o=0 in a read-0 slot SHALL be <= 3 clk cycles.

Reset
REQ-034 nRst=0 at a clock edge: IO_o=1, od_mode=0, reset_det=0, bit_valid=0, bit_data=0, synchronizer=1, counter=0, state IDLE.
REQ-035 Reset SHALL take effect in any state, including mid-presence and mid-read-0 drive; IO_o releases on that edge.

Verification (CLK_MHZ=50)
REQ-036 480us low then release -> reset_det pulse, od_mode=0; IO_o=0 starting 30us (+/-3 cycles) after the rise, for 6000 cycles.
REQ-037 Standard write slots, byte 0x33 LSB first (1: 2.208us low; 0: 57.42us low) -> eight bit_valid with bit_data 1,1,0,0,1,1,0,0.
REQ-038 tx_en=1, tx_bit=0, standard read slot, master low 6.25us -> IO_o=0 within 3 cycles of the fall and held 1500 cycles; tx_bit=1 -> IO_o stays 1; bit_data equals tx_bit.
REQ-039 od_set, then 48.2us low -> reset_det, od_mode=1, presence 3us after the rise for 600 cycles; OD slots 1.208us / 7.333us low -> bits 1 / 0.
REQ-040 od_mode=1, 480us low -> reset_det, od_mode=0, standard presence timing.
REQ-041 Standard mode, 48.2us low -> bit_valid with bit_data=0 and no reset_det.
REQ-042 nRst=0 mid-PRES_DRIVE -> IO_o=1 on the next edge, state IDLE.

Source files
------------

// File: rtl/onewire_slave_phy.sv
// -----------------------------------------------------------------------------
// onewire_slave_phy
//   Bit-level 1-Wire slave physical layer. Detects reset pulses and answers
//   them with a presence pulse, samples write slots, and drives read-0 slots.
//   Supports standard and overdrive timing.
//
// Ports
//   clk        system clock (CLK_MHZ MHz)
//   nRst       synchronous active-low reset
//   IO_i       1-Wire bus level (asynchronous, synchronized internally)
//   IO_o       open-drain drive: 0 pulls the bus low, 1 releases it
//   od_set     one-cycle pulse: switch to overdrive timing
//   tx_en      next slot is a read slot
//   tx_bit     bit returned in a read slot (latched at the slot's falling edge)
//   reset_det  one-cycle pulse: a valid reset pulse ended
//   bit_valid  one-cycle pulse: bit_data holds a slot bit
//   bit_data   slot bit, meaningful while bit_valid=1
//   od_mode    1 = overdrive timing active
// -----------------------------------------------------------------------------
module onewire_slave_phy #(
   parameter int CLK_MHZ = 50
) (
   input  logic clk,
   input  logic nRst,
   input  logic IO_i,
   output logic IO_o,
   input  logic od_set,
   input  logic tx_en,
   input  logic tx_bit,
   output logic reset_det,
   output logic bit_valid,
   output logic bit_data,
   output logic od_mode
);

   // Sample point, read-0 release point and presence wait share one value.
   localparam logic [15:0] T_SLOT_STD = 16'(30 * CLK_MHZ);
   localparam logic [15:0] T_SLOT_OD  = 16'(3 * CLK_MHZ);
   localparam logic [15:0] T_PDL_STD  = 16'(120 * CLK_MHZ);
   localparam logic [15:0] T_PDL_OD   = 16'(12 * CLK_MHZ);
   localparam logic [15:0] T_RST_STD  = 16'(480 * CLK_MHZ);
   localparam logic [15:0] T_RST_OD   = 16'(48 * CLK_MHZ);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_PRES_WAIT,
      ST_PRES_DRIVE
   } state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        prev_q, prev_d;
   logic [15:0] cnt_q, cnt_d;          // bus low time since the last fall
   logic [15:0] slot_q, slot_d;        // time since the last fall, any level
   logic [15:0] pres_q, pres_d;        // presence phase timer
   logic        read_q, read_d;        // latched tx_en
   logic        txb_q, txb_d;          // latched tx_bit
   logic        od_lat_q, od_lat_d;    // timing set for the current slot / presence
   logic        samp_pend_q, samp_pend_d;
   logic        io_o_q, io_o_d;
   logic        od_mode_q, od_mode_d;
   logic        reset_det_q, reset_det_d;
   logic        bit_valid_q, bit_valid_d;
   logic        bit_data_q, bit_data_d;

   logic        fall, rise;
   logic [15:0] t_slot, t_pdl;

   assign fall   = prev_q & ~sync2_q;
   assign rise   = ~prev_q & sync2_q;
   assign t_slot = od_lat_q ? T_SLOT_OD : T_SLOT_STD;
   assign t_pdl  = od_lat_q ? T_PDL_OD : T_PDL_STD;

   always_comb begin
      // NOTE: every *_d starts from a default so no path can infer a latch.
      sync1_d     = IO_i;
      sync2_d     = sync1_q;
      prev_d      = sync2_q;
      cnt_d       = cnt_q;
      slot_d      = slot_q;
      pres_d      = pres_q + 16'd1;
      state_d     = state_q;
      read_d      = read_q;
      txb_d       = txb_q;
      od_lat_d    = od_lat_q;
      samp_pend_d = samp_pend_q;
      io_o_d      = io_o_q;
      od_mode_d   = od_mode_q | od_set;
      reset_det_d = 1'b0;
      bit_valid_d = 1'b0;
      bit_data_d  = bit_data_q;

      if (fall)
         cnt_d = 16'd0;
      else if (!sync2_q && cnt_q != 16'hFFFF)
         cnt_d = cnt_q + 16'd1;

      if (fall)
         slot_d = 16'd0;
      else if (slot_q != 16'hFFFF)
         slot_d = slot_q + 16'd1;

      // The sample point is timed from the fall, so a short write-1 low that
      // has already ended is still sampled (as 1) at the sample point.
      if (samp_pend_q && slot_q == t_slot) begin
         bit_valid_d = 1'b1;
         bit_data_d  = read_q ? txb_q : sync2_q;
         samp_pend_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d     = ST_LOW;
               read_d      = tx_en;
               txb_d       = tx_bit;
               od_lat_d    = od_mode_q;
               samp_pend_d = 1'b1;
               io_o_d      = ~(tx_en & ~tx_bit);
            end
         end

         ST_LOW: begin
            if (cnt_q == t_slot)
               io_o_d = 1'b1;
            if (rise) begin
               io_o_d = 1'b1;
               // The fall cycle is itself a low cycle that the cleared counter
               // does not count, hence the threshold minus one.
               if (cnt_q >= T_RST_STD - 16'd1) begin
                  state_d     = ST_PRES_WAIT;
                  reset_det_d = 1'b1;
                  bit_valid_d = 1'b0;
                  od_mode_d   = 1'b0;       // standard reset beats od_set
                  od_lat_d    = 1'b0;
                  samp_pend_d = 1'b0;
                  pres_d      = 16'd0;
               end else if (od_mode_q && cnt_q >= T_RST_OD - 16'd1) begin
                  state_d     = ST_PRES_WAIT;
                  reset_det_d = 1'b1;
                  bit_valid_d = 1'b0;
                  od_lat_d    = 1'b1;
                  samp_pend_d = 1'b0;
                  pres_d      = 16'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_PRES_WAIT: begin
            if (fall) begin
               // Master cut the presence short: treat it as a low period that
               // may still be a reset, but never deliver a bit from it.
               state_d  = ST_LOW;
               read_d   = 1'b0;
               txb_d    = 1'b0;
               od_lat_d = od_mode_q;
               io_o_d   = 1'b1;
            end else if (pres_q == t_slot - 16'd1) begin
               state_d = ST_PRES_DRIVE;
               io_o_d  = 1'b0;
               pres_d  = 16'd0;
            end
         end

         ST_PRES_DRIVE: begin
            // Our own drive shows up on IO_i; the bus is ignored here.
            if (pres_q == t_pdl - 16'd1) begin
               state_d = ST_IDLE;
               io_o_d  = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            io_o_d  = 1'b1;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         state_q     <= ST_IDLE;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         prev_q      <= 1'b1;
         cnt_q       <= 16'd0;
         slot_q      <= 16'd0;
         pres_q      <= 16'd0;
         read_q      <= 1'b0;
         txb_q       <= 1'b0;
         od_lat_q    <= 1'b0;
         samp_pend_q <= 1'b0;
         io_o_q      <= 1'b1;
         od_mode_q   <= 1'b0;
         reset_det_q <= 1'b0;
         bit_valid_q <= 1'b0;
         bit_data_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         slot_q      <= slot_d;
         pres_q      <= pres_d;
         read_q      <= read_d;
         txb_q       <= txb_d;
         od_lat_q    <= od_lat_d;
         samp_pend_q <= samp_pend_d;
         io_o_q      <= io_o_d;
         od_mode_q   <= od_mode_d;
         reset_det_q <= reset_det_d;
         bit_valid_q <= bit_valid_d;
         bit_data_q  <= bit_data_d;
      end
   end

   assign IO_o      = io_o_q;
   assign od_mode   = od_mode_q;
   assign reset_det = reset_det_q;
   assign bit_valid = bit_valid_q;
   assign bit_data  = bit_data_q;

endmodule

// File: tb/tb_onewire_slave_phy.sv
// -----------------------------------------------------------------------------
// tb_onewire_slave_phy
//   Directed bench for onewire_slave_phy at CLK_MHZ=50 (1 cycle = 20 ns).
//   The bus is modelled as a wired-AND of the master drive and IO_o.
// -----------------------------------------------------------------------------
module tb_onewire_slave_phy;

   logic clk = 1'b0;
   logic nRst;
   logic master;
   logic io_bus;
   logic io_o;
   logic od_set;
   logic tx_en;
   logic tx_bit;
   logic reset_det;
   logic bit_valid;
   logic bit_data;
   logic od_mode;

   int checks = 0;
   int errors = 0;

   int   bv_cnt   = 0;
   int   rd_cnt   = 0;
   int   both_cnt = 0;
   int   low_cnt  = 0;
   logic bits_seen [0:255];

   assign io_bus = master & io_o;

   onewire_slave_phy #(.CLK_MHZ(50)) dut (
      .clk       (clk),
      .nRst      (nRst),
      .IO_i      (io_bus),
      .IO_o      (io_o),
      .od_set    (od_set),
      .tx_en     (tx_en),
      .tx_bit    (tx_bit),
      .reset_det (reset_det),
      .bit_valid (bit_valid),
      .bit_data  (bit_data),
      .od_mode   (od_mode)
   );

   always #10 clk = ~clk;

   // Event recorder, sampled on the inactive edge.
   always @(negedge clk) begin
      if (bit_valid) begin
         if (bv_cnt < 256)
            bits_seen[bv_cnt] = bit_data;
         bv_cnt++;
      end
      if (reset_det)
         rd_cnt++;
      if (reset_det && bit_valid)
         both_cnt++;
      if (io_o === 1'b0)
         low_cnt++;
   end

   initial begin
      #(20 * 120000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic low_pulse(input int low, input int high);
      master = 1'b0;
      step(low);
      master = 1'b1;
      step(high);
   endtask

   // Cycles until IO_o goes low (bounded).
   task automatic wait_io_low(output int n);
      n = 0;
      while (io_o !== 1'b0 && n < 10000) begin
         step(1);
         n++;
      end
   endtask

   // Cycles IO_o stays low; the master releases after release_at cycles.
   task automatic measure_low(input int release_at, output int n);
      n = 0;
      while (io_o === 1'b0 && n < 10000) begin
         if (n == release_at)
            master = 1'b1;
         step(1);
         n++;
      end
      master = 1'b1;
   endtask

   initial begin
      int         n;
      int         m;
      int         bv0;
      int         rd0;
      int         lc0;
      logic [7:0] wr_byte;

      nRst   = 1'b0;
      master = 1'b1;
      od_set = 1'b0;
      tx_en  = 1'b0;
      tx_bit = 1'b0;
      step(3);

      // Reset state
      check("rst_io_o", 32'(io_o), 32'd1);
      check("rst_od_mode", 32'(od_mode), 32'd0);
      check("rst_reset_det", 32'(reset_det), 32'd0);
      check("rst_bit_valid", 32'(bit_valid), 32'd0);
      check("rst_bit_data", 32'(bit_data), 32'd0);
      nRst = 1'b1;
      step(5);

      // Standard reset: 480 us low, presence 30 us after the rise for 6000 cycles
      rd0 = rd_cnt;
      master = 1'b0;
      step(24000);
      master = 1'b1;
      wait_io_low(n);
      check("std_pres_delay", 32'(n >= 1497 && n <= 1503), 32'd1);
      check("std_reset_det", rd_cnt - rd0, 1);
      check("std_od_mode", 32'(od_mode), 32'd0);
      measure_low(-1, m);
      check("std_pres_len", m, 6000);
      step(100);

      // Write byte 0x33 LSB first: 1 = 2.208 us low, 0 = 57.42 us low
      wr_byte = 8'h33;
      bv0 = bv_cnt;
      rd0 = rd_cnt;
      for (int i = 0; i < 8; i++) begin
         if (wr_byte[i])
            low_pulse(110, 1500);
         else
            low_pulse(2871, 200);
      end
      check("wr_bit_count", bv_cnt - bv0, 8);
      for (int i = 0; i < 8; i++)
         check($sformatf("wr_bit%0d", i), 32'(bits_seen[(bv0 + i) % 256]), 32'(wr_byte[i]));
      check("wr_no_reset", rd_cnt - rd0, 0);

      // Read-0 slot: master low 6.25 us, slave holds the bus to 30 us
      bv0 = bv_cnt;
      tx_en  = 1'b1;
      tx_bit = 1'b0;
      master = 1'b0;
      wait_io_low(n);
      tx_en = 1'b0;
      check("rd0_latency", 32'(n <= 3), 32'd1);
      measure_low(312 - n, m);
      check("rd0_hold", 32'(m >= 1500 && m <= 1503), 32'd1);
      step(200);
      check("rd0_bit_count", bv_cnt - bv0, 1);
      check("rd0_bit", 32'(bits_seen[bv0 % 256]), 32'd0);

      // Read-1 slot: slave never drives, bit reports tx_bit
      bv0 = bv_cnt;
      lc0 = low_cnt;
      tx_en  = 1'b1;
      tx_bit = 1'b1;
      master = 1'b0;
      step(312);
      master = 1'b1;
      tx_en  = 1'b0;
      tx_bit = 1'b0;
      step(1600);
      check("rd1_no_drive", low_cnt - lc0, 0);
      check("rd1_bit_count", bv_cnt - bv0, 1);
      check("rd1_bit", 32'(bits_seen[bv0 % 256]), 32'd1);

      // Standard mode 48.2 us low: ordinary 0 slot, no reset
      bv0 = bv_cnt;
      rd0 = rd_cnt;
      low_pulse(2410, 200);
      check("std48_bit_count", bv_cnt - bv0, 1);
      check("std48_bit", 32'(bits_seen[bv0 % 256]), 32'd0);
      check("std48_no_reset", rd_cnt - rd0, 0);

      // Overdrive: od_set, 48.2 us reset, presence 3 us after the rise for 600 cycles
      od_set = 1'b1;
      step(1);
      od_set = 1'b0;
      check("od_set_mode", 32'(od_mode), 32'd1);
      rd0 = rd_cnt;
      master = 1'b0;
      step(2410);
      master = 1'b1;
      wait_io_low(n);
      check("od_pres_delay", 32'(n >= 147 && n <= 153), 32'd1);
      check("od_reset_det", rd_cnt - rd0, 1);
      check("od_mode_kept", 32'(od_mode), 32'd1);
      measure_low(-1, m);
      check("od_pres_len", m, 600);
      step(50);

      // Overdrive slots: 1.208 us low -> 1, 7.333 us low -> 0
      bv0 = bv_cnt;
      low_pulse(60, 200);
      low_pulse(367, 100);
      check("od_bit_count", bv_cnt - bv0, 2);
      check("od_bit1", 32'(bits_seen[bv0 % 256]), 32'd1);
      check("od_bit0", 32'(bits_seen[(bv0 + 1) % 256]), 32'd0);

      // 480 us reset from overdrive, with od_set in the decision cycle
      rd0 = rd_cnt;
      master = 1'b0;
      step(24000);
      master = 1'b1;
      step(2);
      od_set = 1'b1;
      step(1);
      od_set = 1'b0;
      wait_io_low(n);
      n += 3;
      check("od2std_pres_delay", 32'(n >= 1497 && n <= 1503), 32'd1);
      check("od2std_reset_det", rd_cnt - rd0, 1);
      check("od2std_mode", 32'(od_mode), 32'd0);

      // Reset in the middle of the presence drive
      step(100);
      nRst = 1'b0;
      step(1);
      check("midpres_rst_io_o", 32'(io_o), 32'd1);
      nRst = 1'b1;
      lc0 = low_cnt;
      step(200);
      check("midpres_idle", low_cnt - lc0, 0);
      check("midpres_od_mode", 32'(od_mode), 32'd0);

      check("no_pulse_overlap", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
